// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  // One-hot done vector for a given port index.
  function automatic logic [1:0] port_onehot(input logic idx);
    logic [1:0] oh;
    if (idx == PORT_DATA) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. Purely combinational; the caller owns
// the last_grant history bit and updates it when a grant is taken.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Pick the sole requester, or the port that did not win last time on a tie.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = PORT_IF;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_idx   = PORT_IF;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_idx   = PORT_DATA;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_idx   = ~last_grant;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_idx   = PORT_IF;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency single-port memory between the fetch port (0)
// and the data port (1). One transaction in flight, round-robin on ties,
// watchdog abort when the memory never answers.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [1:0]    stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  // Watchdog fires on the cycle the counter sits at TIMEOUT-1 with no answer.
  localparam logic          WD_EN   = (TIMEOUT != 0) ? 1'b1 : 1'b0;
  localparam logic [TW-1:0] WD_LAST = (TIMEOUT == 0) ? {TW{1'b0}} : TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WD_MAX  = {TW{1'b1}};

  state_t        state_r;
  state_t        next_state_s;
  logic          grant_q_r;
  logic          last_grant_r;
  logic [TW-1:0] wd_r;

  logic          gnt_valid_s;
  logic          gnt_idx_s;
  logic          timeout_hit_s;

  logic          mem_req_nx_s;
  logic          mem_we_nx_s;
  logic [AW-1:0] mem_addr_nx_s;
  logic [DW-1:0] mem_wdata_nx_s;
  logic [DW-1:0] rdata_nx_s;
  logic [1:0]    done_nx_s;
  logic          err_nx_s;
  logic [TW-1:0] wd_nx_s;
  logic          grant_nx_s;
  logic          last_grant_nx_s;

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_r),
    .gnt_valid  (gnt_valid_s),
    .gnt_idx    (gnt_idx_s)
  );

  // The pipeline stalls a port while it is requesting and not being completed.
  assign stall = req & ~done;

  // Watchdog expiry decode; disabled entirely when TIMEOUT is zero.
  always_comb begin
    if (WD_EN && (wd_r == WD_LAST)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: grant in IDLE, wait for ready or watchdog in BUSY, one RESP cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          next_state_s = BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          next_state_s = RESP;
        end else if (timeout_hit_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = BUSY;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered memory bus, response and bookkeeping.
  always_comb begin
    mem_req_nx_s    = mem_req;
    mem_we_nx_s     = mem_we;
    mem_addr_nx_s   = mem_addr;
    mem_wdata_nx_s  = mem_wdata;
    rdata_nx_s      = rdata;
    done_nx_s       = 2'b00;
    err_nx_s        = 1'b0;
    wd_nx_s         = wd_r;
    grant_nx_s      = grant_q_r;
    last_grant_nx_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          mem_req_nx_s    = 1'b1;
          grant_nx_s      = gnt_idx_s;
          last_grant_nx_s = gnt_idx_s;
          wd_nx_s         = {TW{1'b0}};
          if (gnt_idx_s == PORT_DATA) begin
            mem_we_nx_s    = we[1];
            mem_addr_nx_s  = addr1;
            mem_wdata_nx_s = wdata1;
          end else begin
            mem_we_nx_s    = we[0];
            mem_addr_nx_s  = addr0;
            mem_wdata_nx_s = wdata0;
          end
        end else begin
          mem_req_nx_s = 1'b0;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rdata_nx_s   = mem_rdata;
          err_nx_s     = 1'b0;
          mem_req_nx_s = 1'b0;
          done_nx_s    = port_onehot(grant_q_r);
        end else if (timeout_hit_s) begin
          rdata_nx_s   = {DW{1'b0}};
          err_nx_s     = 1'b1;
          mem_req_nx_s = 1'b0;
          done_nx_s    = port_onehot(grant_q_r);
        end else begin
          // Hold at the top instead of wrapping when the watchdog is disabled.
          if (wd_r != WD_MAX) begin
            wd_nx_s = wd_r + {{(TW-1){1'b0}}, 1'b1};
          end else begin
            wd_nx_s = wd_r;
          end
        end
      end
      RESP: begin
        mem_req_nx_s = 1'b0;
      end
      default: begin
        mem_req_nx_s = 1'b0;
      end
    endcase
  end

  // Registered outputs and arbitration history; reset drops any in-flight transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {AW{1'b0}};
      mem_wdata    <= {DW{1'b0}};
      rdata        <= {DW{1'b0}};
      done         <= 2'b00;
      err          <= 1'b0;
      wd_r         <= {TW{1'b0}};
      grant_q_r    <= PORT_IF;
      last_grant_r <= PORT_DATA;
    end else begin
      mem_req      <= mem_req_nx_s;
      mem_we       <= mem_we_nx_s;
      mem_addr     <= mem_addr_nx_s;
      mem_wdata    <= mem_wdata_nx_s;
      rdata        <= rdata_nx_s;
      done         <= done_nx_s;
      err          <= err_nx_s;
      wd_r         <= wd_nx_s;
      grant_q_r    <= grant_nx_s;
      last_grant_r <= last_grant_nx_s;
    end
  end

endmodule
